// File: rtl/cache_inval_engine_pkg.sv
// Shared cache geometry and invalidation-engine state encodings.
package cache_inval_engine_pkg;
    localparam int INDEX_LENGTH   = 6;
    localparam int CACHE_LINE_NUM = 2 ** INDEX_LENGTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_SINGLE = 2'd2,
        ST_DONE   = 2'd3
    } inval_state_t;
endpackage

// File: rtl/cache_inval_engine_counter.sv
// Sweep index counter: load-zero, increment, terminal-count flag at the last line.
module inval_index_counter
    import cache_inval_engine_pkg::*;
#(
    parameter int INDEX_LENGTH = cache_inval_engine_pkg::INDEX_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    inc,
    output logic [INDEX_LENGTH-1:0] count,
    output logic                    last
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + INDEX_LENGTH'(1);
        end
    end

    assign last = &count;
endmodule

// File: rtl/cache_inval_engine.sv
// Valid-RAM invalidation engine: full flush sweep or single-line invalidate,
// owning the valid RAM write port while busy and passing controller writes through otherwise.
module cache_inval_engine
    import cache_inval_engine_pkg::*;
#(
    parameter int INDEX_LENGTH = cache_inval_engine_pkg::INDEX_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_req,
    input  logic                    inv_req,
    input  logic [INDEX_LENGTH-1:0] inv_index,
    input  logic                    ctrl_w_en,
    input  logic [INDEX_LENGTH-1:0] ctrl_index,
    input  logic                    ctrl_valid_in,
    input  logic                    valid_rd,
    output logic                    vr_w_en,
    output logic [INDEX_LENGTH-1:0] vr_index,
    output logic                    vr_valid_in,
    output logic                    busy,
    output logic                    ctrl_stall,
    output logic                    done,
    output logic [INDEX_LENGTH:0]   cleared_cnt
);
    inval_state_t            state;
    logic [INDEX_LENGTH-1:0] inv_index_q;
    logic [INDEX_LENGTH-1:0] sweep_index;
    logic                    sweep_last;

    inval_index_counter #(.INDEX_LENGTH(INDEX_LENGTH)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE && flush_req),
        .inc   (state == ST_SWEEP && !sweep_last),
        .count (sweep_index),
        .last  (sweep_last)
    );

    // busy and done are registered with the state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            inv_index_q <= '0;
            cleared_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state       <= ST_SWEEP;
                        busy        <= 1'b1;
                        cleared_cnt <= '0;
                    end else if (inv_req) begin
                        state       <= ST_SINGLE;
                        busy        <= 1'b1;
                        inv_index_q <= inv_index;
                        cleared_cnt <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (valid_rd) cleared_cnt <= cleared_cnt + (INDEX_LENGTH+1)'(1);
                    if (sweep_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_SINGLE: begin
                    cleared_cnt <= {{INDEX_LENGTH{1'b0}}, valid_rd};
                    state       <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Engine writes only ever clear a line, and only one that reads valid.
    always_comb begin
        vr_w_en     = 1'b0;
        vr_index    = sweep_index;
        vr_valid_in = 1'b0;
        case (state)
            ST_IDLE: begin
                vr_w_en     = ctrl_w_en;
                vr_index    = ctrl_index;
                vr_valid_in = ctrl_valid_in;
            end
            ST_SWEEP:  vr_w_en = valid_rd;
            ST_SINGLE: begin
                vr_w_en  = valid_rd;
                vr_index = inv_index_q;
            end
            default: ;
        endcase
    end

    assign ctrl_stall = busy;
endmodule

// File: tb/tb_cache_inval_engine.sv
// Directed bench for cache_inval_engine with a behavioural 64-line valid RAM.
module tb_cache_inval_engine;
    localparam int IL = 6;
    localparam int N  = 64;

    logic          clk;
    logic          rst;
    logic          flush_req;
    logic          inv_req;
    logic [IL-1:0] inv_index;
    logic          ctrl_w_en;
    logic [IL-1:0] ctrl_index;
    logic          ctrl_valid_in;
    logic          valid_rd;
    logic          vr_w_en;
    logic [IL-1:0] vr_index;
    logic          vr_valid_in;
    logic          busy;
    logic          ctrl_stall;
    logic          done;
    logic [IL:0]   cleared_cnt;

    logic [N-1:0]  ram;
    int            checks = 0;
    int            errors = 0;

    int            bc, wc, dc, bad;
    logic [N-1:0]  wm;

    cache_inval_engine #(.INDEX_LENGTH(IL)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_req     (flush_req),
        .inv_req       (inv_req),
        .inv_index     (inv_index),
        .ctrl_w_en     (ctrl_w_en),
        .ctrl_index    (ctrl_index),
        .ctrl_valid_in (ctrl_valid_in),
        .valid_rd      (valid_rd),
        .vr_w_en       (vr_w_en),
        .vr_index      (vr_index),
        .vr_valid_in   (vr_valid_in),
        .busy          (busy),
        .ctrl_stall    (ctrl_stall),
        .done          (done),
        .cleared_cnt   (cleared_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign valid_rd = ram[vr_index];
    always @(posedge clk) if (vr_w_en) ram[vr_index] <= vr_valid_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [N-1:0] pat);
        for (int i = 0; i < N; i++) begin
            ctrl_w_en     = 1'b1;
            ctrl_index    = IL'(i);
            ctrl_valid_in = pat[i];
            @(negedge clk);
        end
        ctrl_w_en = 1'b0;
    endtask

    // Samples mid-cycle for a fixed number of cycles, recording engine activity.
    task automatic monitor(input int cycles, output int b, output logic [N-1:0] m,
                           output int w, output int d, output int v);
        b = 0; m = '0; w = 0; d = 0; v = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (busy) b++;
            if (busy && vr_w_en) begin
                m[vr_index] = 1'b1;
                w++;
                if (vr_valid_in) v++;
            end
            if (done) begin
                d++;
                if (busy) v++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush_req = 1'b0; inv_req = 1'b0; inv_index = '0;
        ctrl_w_en = 1'b0; ctrl_index = '0; ctrl_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cleared", 64'(cleared_cnt), 64'd0);
        chk("rst_stall", 64'(ctrl_stall), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Flush with lines 3, 10, 63 valid
        preload((64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63));
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        monitor(70, bc, wm, wc, dc, bad);
        chk("flush_busy_cycles", 64'(bc), 64'd64);
        chk("flush_write_mask", wm, (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63));
        chk("flush_write_count", 64'(wc), 64'd3);
        chk("flush_done_pulses", 64'(dc), 64'd1);
        chk("flush_no_set_write", 64'(bad), 64'd0);
        chk("flush_cleared", 64'(cleared_cnt), 64'd3);
        chk("flush_ram", ram, 64'd0);

        // Single invalidate of a valid line, then of an invalid one
        ctrl_w_en = 1'b1; ctrl_index = 6'd5; ctrl_valid_in = 1'b1;
        @(negedge clk);
        ctrl_w_en = 1'b0;
        chk("inv_preload", ram, 64'd1 << 5);
        inv_req = 1'b1; inv_index = 6'd5;
        @(negedge clk);
        inv_req = 1'b0;
        monitor(4, bc, wm, wc, dc, bad);
        chk("inv_busy_cycles", 64'(bc), 64'd1);
        chk("inv_write_mask", wm, 64'd1 << 5);
        chk("inv_done_pulses", 64'(dc), 64'd1);
        chk("inv_cleared", 64'(cleared_cnt), 64'd1);
        chk("inv_ram", ram, 64'd0);
        inv_req = 1'b1; inv_index = 6'd5;
        @(negedge clk);
        inv_req = 1'b0;
        monitor(4, bc, wm, wc, dc, bad);
        chk("inv2_busy_cycles", 64'(bc), 64'd1);
        chk("inv2_write_count", 64'(wc), 64'd0);
        chk("inv2_done_pulses", 64'(dc), 64'd1);
        chk("inv2_cleared", 64'(cleared_cnt), 64'd0);

        // Flush and invalidate together: flush wins
        preload((64'd1 << 7) | (64'd1 << 20));
        flush_req = 1'b1; inv_req = 1'b1; inv_index = 6'd7;
        @(negedge clk);
        flush_req = 1'b0; inv_req = 1'b0;
        monitor(70, bc, wm, wc, dc, bad);
        chk("both_busy_cycles", 64'(bc), 64'd64);
        chk("both_write_mask", wm, (64'd1 << 7) | (64'd1 << 20));
        chk("both_done_pulses", 64'(dc), 64'd1);
        chk("both_cleared", 64'(cleared_cnt), 64'd2);

        // Controller write to line 12 during a sweep is dropped
        preload(64'd0);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        ctrl_w_en = 1'b1; ctrl_index = 6'd12; ctrl_valid_in = 1'b1;
        #1;
        chk("sweep_stall", 64'(ctrl_stall), 64'd1);
        chk("sweep_vr_valid_in", 64'(vr_valid_in), 64'd0);
        @(negedge clk);
        monitor(10, bc, wm, wc, dc, bad);
        ctrl_w_en = 1'b0;
        monitor(60, bc, wm, wc, dc, bad);
        chk("stall_cleared", 64'(cleared_cnt), 64'd0);
        chk("stall_ram", ram, 64'd0);
        ctrl_w_en = 1'b1; ctrl_index = 6'd12; ctrl_valid_in = 1'b1;
        #1;
        chk("idle_pass_w_en", 64'(vr_w_en), 64'd1);
        chk("idle_pass_index", 64'(vr_index), 64'd12);
        chk("idle_pass_valid", 64'(vr_valid_in), 64'd1);
        chk("idle_stall", 64'(ctrl_stall), 64'd0);
        @(negedge clk);
        ctrl_w_en = 1'b0;
        chk("idle_pass_ram", ram, 64'd1 << 12);

        // All lines valid: count reaches 64 without overflow
        preload({N{1'b1}});
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        monitor(70, bc, wm, wc, dc, bad);
        chk("full_write_count", 64'(wc), 64'd64);
        chk("full_cleared", 64'(cleared_cnt), 64'd64);
        chk("full_ram", ram, 64'd0);
        chk("full_no_set_write", 64'(bad), 64'd0);

        // Reset at sweep index 20 aborts without done
        preload({N{1'b1}});
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_index", 64'(vr_index), 64'd20);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cleared", 64'(cleared_cnt), 64'd0);
        chk("abort_vr_w_en", 64'(vr_w_en), 64'd0);
        @(negedge clk);
        monitor(3, bc, wm, wc, dc, bad);
        chk("abort_done_pulses", 64'(dc), 64'd0);
        chk("abort_ram", ram, {{44{1'b1}}, 20'd0});
        rst = 1'b1; inv_req = 1'b1; inv_index = 6'd25;
        @(negedge clk);
        inv_req = 1'b0;
        #1;
        chk("post_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("post_rst_done", 64'(done), 64'd1);
        chk("post_rst_cleared", 64'(cleared_cnt), 64'd1);
        @(negedge clk);
        chk("post_rst_ram", ram, {{38{1'b1}}, 1'b0, 5'h1f, 20'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_inval_engine.md
CACHE_INVAL_ENGINE -- requirements
Module: cache_inval_engine

Interface
REQ-001 Parameter INDEX_LENGTH, default 6, index width; CACHE_LINE_NUM = 2**INDEX_LENGTH lines.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush_req  input  1  level request: invalidate every line.
REQ-005 inv_req  input  1  level request: invalidate one line.
REQ-006 inv_index  input  INDEX_LENGTH  line targeted by inv_req.
REQ-007 ctrl_w_en / ctrl_index / ctrl_valid_in  input  1 / INDEX_LENGTH / 1  cache-controller write port into the valid RAM.
REQ-008 valid_rd  input  1  combinational valid-bit readback from the valid RAM at vr_index.
REQ-009 vr_w_en / vr_index / vr_valid_in  output  1 / INDEX_LENGTH / 1  write port driven into the valid RAM.
REQ-010 busy  output  1  engine owns the valid RAM write port.
REQ-011 ctrl_stall  output  1  controller write dropped this cycle; equals busy.
REQ-012 done  output  1  one-cycle pulse ending an accepted request.
REQ-013 cleared_cnt  output  INDEX_LENGTH+1  count of lines found valid and cleared by the last operation.

Function
REQ-014 FSM states: IDLE, SWEEP, SINGLE, DONE; state is registered.
REQ-015 IDLE: vr_* = ctrl_* combinationally (pass-through); busy=0.
REQ-016 IDLE with flush_req=1: go to SWEEP next cycle, index counter=0, cleared_cnt=0.
REQ-017 IDLE with inv_req=1 and flush_req=0: latch inv_index, go to SINGLE, cleared_cnt=0.
REQ-018 flush_req and inv_req both high in IDLE: flush wins, inv_req is not serviced.
REQ-019 SWEEP: vr_index = index counter; vr_valid_in=0; vr_w_en = valid_rd (write only lines currently valid).
REQ-020 SWEEP: cleared_cnt increments by 1 in each cycle where valid_rd=1.
REQ-021 SWEEP: counter increments every cycle; at CACHE_LINE_NUM-1 go to DONE, no wrap to 0 while in SWEEP.
REQ-022 SWEEP duration = exactly CACHE_LINE_NUM cycles regardless of contents.
REQ-023 SINGLE: one cycle; vr_index = latched index, vr_valid_in=0, vr_w_en = valid_rd, cleared_cnt = valid_rd; then DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, vr_w_en=0, ctrl_* dropped; next state IDLE.
REQ-025 busy=1 in SWEEP and SINGLE; controller writes during busy are discarded, not queued.
REQ-026 Requests arriving in SWEEP/SINGLE/DONE are ignored; a still-high request re-triggers from IDLE.
REQ-027 cleared_cnt holds its value in IDLE until the next accepted request; max value CACHE_LINE_NUM does not overflow.
REQ-028 vr_w_en never asserts with vr_valid_in=1 outside IDLE.

Reset
REQ-029 rst low: immediately state=IDLE, index counter=0, latched index=0, cleared_cnt=0, done=0, busy=0.
REQ-030 rst asserted mid-SWEEP/SINGLE aborts the operation without done pulse; partial invalidations stand.
REQ-031 After rst deassert, the first accepted request is evaluated on the first posedge.

Structure
REQ-032 INDEX_LENGTH and CACHE_LINE_NUM come from the shared cache define/macro file used by all cache components.
REQ-033 FSM state encodings are defined in that shared file.
REQ-034 Single natural sub-module: inval_index_counter (load-zero, increment, terminal-count flag).

Verification
REQ-035 Reset, lines 3,10,63 valid, flush_req=1 one cycle -> busy for 64 cycles, vr_w_en exactly at indices 3,10,63, done pulse, cleared_cnt=3.
REQ-036 Line 5 valid, inv_req=1 inv_index=5 -> one SINGLE cycle writing 0 to index 5, done next cycle, cleared_cnt=1; repeat on invalid line -> no write, cleared_cnt=0.
REQ-037 flush_req and inv_req (index 7) same cycle -> full sweep only, single path never entered.
REQ-038 ctrl_w_en=1 index 12 during SWEEP -> ctrl_stall=1, RAM line 12 unaffected by controller; ctrl write in IDLE passes through same cycle.
REQ-039 All 64 lines valid, flush -> cleared_cnt=64 (no overflow), all lines read invalid afterwards.
REQ-040 rst low at sweep index 20 -> no done pulse, outputs at reset values, lines 0-19 cleared, 20-63 unchanged.
